// File: rtl/regfile_loader_pkg.sv
// Shared definitions for the register-file loader.
// Holds the data/select widths, the sequencer state encoding and the
// values every register takes on asynchronous reset.
package regfile_pkg;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    // Index of the final register in a frame; loading it ends the load phase
    // and reading it back ends the frame.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WFIN = 3'd2,
        SEL  = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam state_t             RST_STATE = IDLE;
    localparam logic [WIDTH-1:0]   RST_DATA  = '0;
    localparam logic [ADDR_W-1:0]  RST_IDX   = '0;
    localparam logic               RST_FLAG  = 1'b0;

endpackage

// File: rtl/regfile_loader_if.sv
// Bus bundle between the loader and its environment.
// Carries the input byte stream, the output byte stream and the
// register-file write/read port.
//   slave  : the loader side (consumes in_*, drives rf_* and out_*)
//   master : the environment side (producer, consumer and register file)
// Handshake rule for both streams: a transfer happens on the rising clock
// edge where valid and ready are both high; valid never depends on ready,
// and a raised valid with its data stays put until that transfer.
interface regfile_loader_if;
    import regfile_pkg::*;

    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;

    logic [WIDTH-1:0]  rf_d;
    logic [ADDR_W-1:0] rf_sel;
    logic              rf_we;
    logic [WIDTH-1:0]  rf_q;

    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, out_ready, rf_q,
        output in_ready, out_data, out_valid, rf_d, rf_sel, rf_we
    );

    modport master (
        output in_data, in_valid, out_ready, rf_q,
        input  in_ready, out_data, out_valid, rf_d, rf_sel, rf_we
    );

endinterface

// File: rtl/regfile_loader_wrap_counter.sv
// Wrapping index counter.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset, clears the count
//   i_inc  : advance by one, wrapping from all-ones to zero
//   i_clr  : synchronous clear, takes priority over i_inc
//   o_count: current count
module wrap_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/regfile_loader.sv
// Streaming front end and readback sequencer for a 4x8 register file.
// Four accepted input bytes are written to registers 0..3, then the file is
// read back one register at a time and each byte is offered on the output
// stream.
// Ports:
//   clk        : clock, all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous abort of the current frame
//   bus        : input stream, output stream and register-file port
//   busy       : high except in IDLE and in LOAD before the first byte
//   frame_done : one-cycle pulse after the last readback transfer
//   dbg_state  : current sequencer state
module regfile_loader
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    regfile_loader_if.slave    bus,
    output logic               busy,
    output logic               frame_done,
    output state_t             dbg_state
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] w_idx;
    logic              w_idx_inc;
    logic              w_idx_clr;

    logic [WIDTH-1:0]  r_rf_d;
    logic [ADDR_W-1:0] r_rf_sel;
    logic              r_rf_we;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_frame_done;

    logic [WIDTH-1:0]  w_rf_d_nxt;
    logic [ADDR_W-1:0] w_rf_sel_nxt;
    logic              w_rf_we_nxt;
    logic [WIDTH-1:0]  w_out_data_nxt;
    logic              w_out_valid_nxt;
    logic              w_frame_done_nxt;
    logic              w_in_ready;

    wrap_counter #(
        .W (ADDR_W)
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_idx_inc),
        .i_clr   (w_idx_clr),
        .o_count (w_idx)
    );

    assign w_in_ready = (r_state == LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RST_STATE;
            r_rf_d       <= RST_DATA;
            r_rf_sel     <= RST_IDX;
            r_rf_we      <= RST_FLAG;
            r_out_data   <= RST_DATA;
            r_out_valid  <= RST_FLAG;
            r_frame_done <= RST_FLAG;
        end else begin
            r_state      <= w_state_nxt;
            r_rf_d       <= w_rf_d_nxt;
            r_rf_sel     <= w_rf_sel_nxt;
            r_rf_we      <= w_rf_we_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_inc        = 1'b0;
        w_idx_clr        = 1'b0;
        w_rf_d_nxt       = r_rf_d;
        w_rf_sel_nxt     = r_rf_sel;
        w_rf_we_nxt      = 1'b0;
        w_out_data_nxt   = r_out_data;
        w_out_valid_nxt  = r_out_valid;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt = LOAD;
            end

            LOAD: begin
                if (bus.in_valid) begin
                    w_rf_d_nxt   = bus.in_data;
                    w_rf_sel_nxt = w_idx;
                    w_rf_we_nxt  = 1'b1;
                    if (w_idx == LAST_IDX) begin
                        w_idx_clr   = 1'b1;
                        w_state_nxt = WFIN;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end

            WFIN: begin
                // rf_sel must keep addressing the last register while its
                // strobe is live; it moves to the readback index only on the
                // edge that enters SEL.
                w_rf_sel_nxt = w_idx;
                w_state_nxt  = SEL;
            end

            SEL: begin
                w_out_data_nxt  = bus.rf_q;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = OUT;
            end

            OUT: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (w_idx < LAST_IDX) begin
                        w_idx_inc    = 1'b1;
                        w_rf_sel_nxt = w_idx + ADDR_W'(1);
                        w_state_nxt  = SEL;
                    end else begin
                        w_idx_clr        = 1'b1;
                        w_frame_done_nxt = 1'b1;
                        w_state_nxt      = LOAD;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides every handshake decided above, including an input
        // accept in the same cycle, so the byte is neither strobed nor latched.
        if (clear && (r_state != IDLE)) begin
            w_state_nxt      = LOAD;
            w_idx_inc        = 1'b0;
            w_idx_clr        = 1'b1;
            w_rf_d_nxt       = r_rf_d;
            w_rf_sel_nxt     = r_rf_sel;
            w_rf_we_nxt      = 1'b0;
            w_out_data_nxt   = r_out_data;
            w_out_valid_nxt  = 1'b0;
            w_frame_done_nxt = 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.rf_d      = r_rf_d;
    assign bus.rf_sel    = r_rf_sel;
    assign bus.rf_we     = r_rf_we;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;

    assign busy       = (r_state != IDLE) && !((r_state == LOAD) && (w_idx == RST_IDX));
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_regfile_loader.sv
module tb_regfile_loader;
    import regfile_pkg::*;

    logic   clk;
    logic   rst_n;
    logic   clear;
    logic   busy;
    logic   frame_done;
    state_t dbg_state;

    regfile_loader_if bus ();

    regfile_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register file model ----------------
    logic [7:0] rf_mem [4];
    initial begin
        for (int i = 0; i < 4; i++) rf_mem[i] = 8'h00;
    end
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_sel] <= bus.rf_d;
    end
    assign bus.rf_q = rf_mem[bus.rf_sel];

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.rf_we) wr_cnt = wr_cnt + 1;
            if (bus.out_valid && bus.out_ready) begin
                n_checks = n_checks + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_unexpected: got out_data=%h, expected no transfer", bus.out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin
                        n_fail = n_fail + 1;
                        $display("FAIL sb_data: got %h, expected %h", bus.out_data, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // bytes[7:0] go to register 0, bytes[31:24] to register 3
    task automatic send_frame(input logic [31:0] bytes);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = bytes[8*i +: 8];
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] bytes);
        for (int i = 0; i < 4; i++) exp_q.push_back(bytes[8*i +: 8]);
    endtask

    task automatic wait_out_valid(input int budget);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        if (!bus.out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid_timeout: got out_valid=0 after %0d cycles, expected 1", budget);
        end
    endtask

    task automatic wait_frame_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!frame_done && cyc < 60);
        if (!frame_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_timeout: got frame_done=0 after %0d cycles, expected 1", cyc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.in_ready, bus.rf_we, bus.out_valid, frame_done, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {bus.in_ready, bus.rf_we, bus.out_valid, frame_done, busy});
        end
        n_checks++;
        if ({bus.rf_d, bus.rf_sel, bus.out_data} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, expected 0", {bus.rf_d, bus.rf_sel, bus.out_data});
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_ready: got %b, expected 0", bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_load: got in_ready=%b busy=%b, expected 1 0", bus.in_ready, busy);
        end
    endtask

    task automatic test_stream();
        logic [31:0] frame;
        int          t;
        frame = 32'h44332211;
        push_exp(frame);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = frame[8*i +: 8];
            tick();
            n_checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_sel !== 2'(i) || bus.rf_d !== frame[8*i +: 8]) begin
                n_fail++;
                $display("FAIL stream_write%0d: got we=%b sel=%0d d=%h, expected 1 %0d %h",
                         i, bus.rf_we, bus.rf_sel, bus.rf_d, i, frame[8*i +: 8]);
            end
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (dbg_state !== WFIN || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_wfin: got state=%0d in_ready=%b busy=%b, expected %0d 0 1",
                     dbg_state, bus.in_ready, busy, WFIN);
        end
        t = 4;
        do begin
            tick();
            t++;
            if (t == 5) begin
                n_checks++;
                if (bus.rf_we !== 1'b0 || bus.rf_sel !== 2'd0 || dbg_state !== SEL) begin
                    n_fail++;
                    $display("FAIL stream_sel0: got we=%b sel=%0d state=%0d, expected 0 0 %0d",
                             bus.rf_we, bus.rf_sel, dbg_state, SEL);
                end
            end
        end while (!frame_done && t < 40);
        n_checks++;
        if (t !== 13) begin
            n_fail++;
            $display("FAIL stream_frame_cycle: got %0d, expected 13", t);
        end
        tick();
        n_checks++;
        if (frame_done !== 1'b0 || bus.in_ready !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_after: got frame_done=%b in_ready=%b pending=%0d, expected 0 1 0",
                     frame_done, bus.in_ready, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int c;
        push_exp(32'h24232221);
        bus.out_ready = 1'b0;
        send_byte(8'h21, 0);
        send_byte(8'h22, 1);
        send_byte(8'h23, 2);
        send_byte(8'h24, 0);
        wait_out_valid(10);
        n_checks++;
        if (bus.out_data !== 8'h21) begin
            n_fail++;
            $display("FAIL bp_first: got %h, expected 21", bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        wait_out_valid(4);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h, expected 1 22",
                         i, bus.out_valid, bus.out_data);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        wait_frame_done(c);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_clear();
        int c;
        bus.out_ready = 1'b1;
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.rf_d !== 8'h66) begin
            n_fail++;
            $display("FAIL clear_state: got we=%b in_ready=%b busy=%b rf_d=%h, expected 0 1 0 66",
                     bus.rf_we, bus.in_ready, busy, bus.rf_d);
        end
        push_exp(32'hA3A2A1A0);
        send_frame(32'hA3A2A1A0);
        wait_frame_done(c);
        n_checks++;
        if ({rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]} !== 32'hA3A2A1A0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL clear_reload: got mem=%h pending=%0d, expected a3a2a1a0 0",
                     {rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]}, exp_q.size());
        end
    endtask

    task automatic test_reset_during_out();
        bus.out_ready = 1'b0;
        send_frame(32'h34333231);
        wait_out_valid(10);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.rf_we !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b we=%b in_ready=%b busy=%b, expected 0 0 0 0",
                     bus.out_valid, bus.rf_we, bus.in_ready, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_release: got in_ready=%b state=%0d, expected 0 %0d",
                     bus.in_ready, dbg_state, IDLE);
        end
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1 || {rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]} !== 32'h34333231) begin
            n_fail++;
            $display("FAIL rst_recover: got in_ready=%b mem=%h, expected 1 34333231",
                     bus.in_ready, {rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]});
        end
    endtask

    task automatic test_ignored_input();
        int c;
        int snap;
        push_exp(32'h44434241);
        bus.out_ready = 1'b0;
        send_frame(32'h44434241);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        wait_out_valid(10);
        snap = wr_cnt;
        tick();
        tick();
        bus.out_ready = 1'b1;
        wait_frame_done(c);
        bus.in_valid = 1'b0;
        n_checks++;
        if (wr_cnt !== snap || {rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]} !== 32'h44434241) begin
            n_fail++;
            $display("FAIL ignored_input: got writes=%0d mem=%h, expected %0d 44434241",
                     wr_cnt, {rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]}, snap);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        bus.out_ready = 1'b1;
        push_exp(32'h04030201);
        send_frame(32'h04030201);
        wait_frame_done(c);
        n_checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== LOAD) begin
            n_fail++;
            $display("FAIL b2b_between: got busy=%b in_ready=%b state=%0d, expected 0 1 %0d",
                     busy, bus.in_ready, dbg_state, LOAD);
        end
        push_exp(32'hF4F3F2F1);
        send_frame(32'hF4F3F2F1);
        wait_frame_done(c);
        n_checks++;
        if (c !== 9) begin
            n_fail++;
            $display("FAIL b2b_cycles: got %0d cycles after last accept, expected 9", c);
        end
        n_checks++;
        if ({rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]} !== 32'hF4F3F2F1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_second: got mem=%h pending=%0d, expected f4f3f2f1 0",
                     {rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]}, exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_clear();
        test_reset_during_out();
        test_ignored_input();
        test_back_to_back();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_loader.md
# regfile_loader

Sequencer directly upstream of the 4×8 register file. Accepts a frame of four bytes over a valid/ready stream and writes them into registers 0..3 in order via the file's data, select and write-strobe inputs. It then scans the file back out, driving select and capturing the read port, and presents each byte on an output valid/ready stream. This gives the register file a streaming front end and a built-in readback path.

## Interface
- WIDTH, 8, data width; matches the register file word.
- DEPTH, 4, registers per frame; must be a power of two.
- ADDR_W, 2, log2(DEPTH); width of the select bus.
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- clear  input  1  synchronous abort; discards the partial frame.
- in_data  input  WIDTH  byte to be written.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- rf_d  output  WIDTH  write data to the register file.
- rf_sel  output  ADDR_W  register select, used for both write and read.
- rf_we  output  1  one-cycle write strobe for register rf_sel.
- rf_q  input  WIDTH  register file read data for rf_sel; combinational in the file.
- out_data  output  WIDTH  readback byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in every state except IDLE and LOAD-with-idx-0.
- frame_done  output  1  one-cycle pulse after the last readback handshake.

## Operation
- State machine has states IDLE, LOAD, WFIN, SEL and OUT. A 2-bit index idx counts 0..DEPTH-1 and wraps.
- **IDLE** (reset state): unconditionally moves to LOAD on the next edge.
- **LOAD**: in_ready=1.
  - On an in_valid&in_ready edge, register rf_d=in_data, rf_sel=idx, rf_we=1 for the following cycle only, then idx++.
  - The accept with idx==DEPTH-1 moves to WFIN and sets idx to 0.
- **WFIN**: in_ready=0. The final write strobe is active this cycle. Next state is SEL.
- **SEL**: rf_sel=idx, rf_we=0. On the next edge, capture rf_q into out_data, set out_valid=1, and go to OUT.
- **OUT**: out_valid and out_data are held stable until out_ready.
  - On the handshake edge, out_valid drops to 0.
  - If idx<DEPTH-1: idx++ and go to SEL.
  - Otherwise: idx=0, frame_done=1 for one cycle, go to LOAD.
- rf_we is never asserted outside the cycle following a LOAD accept.
- rf_d and rf_sel hold their last values whenever they are not updated.
- **clear** (any state except IDLE): on the next edge go to LOAD with idx=0, out_valid=0, rf_we=0 and frame_done=0. Any write already strobed is not undone. clear has priority over every handshake in the same cycle.
- in_valid in any state other than LOAD is ignored, and the data is not consumed.
- out_ready with out_valid=0 has no effect.

## Timing
- Reset values (asynchronous): state=IDLE, idx=0, in_ready=0, rf_d=0, rf_sel=0, rf_we=0, out_data=0, out_valid=0, frame_done=0, busy=0.
- in_ready first rises one cycle after rst_n deasserts, i.e. in the first cycle in LOAD.
- Write latency: a byte accepted at edge N has rf_we=1 during cycle N+1.
- Back-to-back accepts are allowed, giving one write per cycle.
- Readback cadence: SEL takes one cycle and OUT takes at least one. Minimum of 2 cycles per output byte with out_ready tied high.
- Minimum frame: 4 load cycles + 1 WFIN + 4×2 readback = 13 cycles from the first accept to frame_done.
- rst_n asserted mid-frame forces all outputs to their reset values immediately and discards the frame. Register file contents are not cleared.
- All outputs are registered except in_ready and busy, which decode from state and idx.

## Structure
- Package regfile_pkg holds:
  - WIDTH, DEPTH and ADDR_W localparams;
  - the state enum {IDLE, LOAD, WFIN, SEL, OUT};
  - the reset-value constants.
- One sub-module, wrap_counter: an ADDR_W-bit counter with inc, sync clr and asynchronous rst_n, used for idx.
- Everything else lives in a single FSM module.

## Test plan
- **Reset then stream.** Reset, then stream 0x11,0x22,0x33,0x44 with in_valid held high.
  - rf_we pulses on 4 consecutive cycles with rf_sel 0,1,2,3.
  - Readback yields 0x11,0x22,0x33,0x44, and frame_done pulses once at cycle 13.
- **Input gaps and output backpressure.** Insert gaps in in_valid and hold out_ready=0 for 5 cycles in OUT.
  - out_data stays 0x22 and out_valid stays high until the handshake; there is no duplicate or skipped byte.
- **Clear mid-frame.** Assert clear after 2 accepts, then load 0xA0..0xA3.
  - idx restarts at 0, and readback is 0xA0..0xA3.
- **Reset during OUT.** Assert rst_n=0 while in OUT.
  - out_valid, rf_we and in_ready go to 0 immediately.
  - After release, in_ready rises one cycle later.
- **Ignored input.** Drive in_valid=1 during SEL and OUT with in_data 0xFF.
  - No rf_we pulse occurs, and the value is not written.
- **Two consecutive frames.** Load 0x01..0x04, then 0xF1..0xF4.
  - The second readback returns 0xF1..0xF4, and idx wraps cleanly between frames.
